// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: RV32I size codes, FSM states
// and the legality checks used on every incoming request.
package load_store_unit_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_WRITE = 1'b1
  } lsu_state_e;

  // Reserved size codes, and unsigned variants used with a store.
  function automatic logic is_illegal(input logic [2:0] f3, input logic we);
    return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) || (we && f3[2]);
  endfunction

  // Halfwords need an even byte address, words a multiple of four.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] lo);
    return (((f3 == F3_H) || (f3 == F3_HU)) && lo[0]) ||
           ((f3 == F3_W) && (lo != 2'b00));
  endfunction

endpackage

// File: rtl/load_store_unit_lane_mux.sv
// Byte/halfword lane handling: extracts and extends load data from a memory
// word, and builds the merged word for a sub-word store.
module lsu_lane_mux
  import load_store_unit_pkg::*;
(
  input  logic [31:0] mem_rd,
  input  logic [31:0] wdata,
  input  logic [1:0]  byte_off,
  input  logic [2:0]  funct3,
  output logic [31:0] load_data,
  output logic [31:0] merge_data
);

  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic        is_byte;
  logic        is_half;
  logic [3:0]  lane_sel;
  logic        unused_wdata_hi;

  // Only the low halfword of the store data can ever land in memory here.
  assign unused_wdata_hi = ^wdata[31:16];

  assign is_byte = (funct3[1:0] == 2'b00);
  assign is_half = (funct3[1:0] == 2'b01);

  // Pick the addressed byte and halfword out of the fetched word.
  always_comb begin
    lane_byte = mem_rd[7:0];
    case (byte_off)
      2'd0: lane_byte = mem_rd[7:0];
      2'd1: lane_byte = mem_rd[15:8];
      2'd2: lane_byte = mem_rd[23:16];
      2'd3: lane_byte = mem_rd[31:24];
      default: lane_byte = mem_rd[7:0];
    endcase
    lane_half = byte_off[1] ? mem_rd[31:16] : mem_rd[15:0];
  end

  // Sign- or zero-extend according to the size code; unknown codes yield 0.
  always_comb begin
    load_data = 32'h0;
    case (funct3)
      F3_B:  load_data = {{24{lane_byte[7]}}, lane_byte};
      F3_BU: load_data = {24'h0, lane_byte};
      F3_H:  load_data = {{16{lane_half[15]}}, lane_half};
      F3_HU: load_data = {16'h0, lane_half};
      F3_W:  load_data = mem_rd;
      default: load_data = 32'h0;
    endcase
  end

  // Per byte lane: replace with store data when the lane is addressed,
  // otherwise keep the old memory contents.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    localparam logic [1:0] LANE = 2'(gi);
    assign lane_sel[gi] = (is_byte && (byte_off == LANE)) ||
                          (is_half && (byte_off[1] == LANE[1]));
    assign merge_data[8*gi +: 8] = !lane_sel[gi] ? mem_rd[8*gi +: 8] :
                                   is_half       ? wdata[8*(gi%2) +: 8] :
                                                   wdata[7:0];
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: converts RV32I byte/half/word accesses into word accesses
// on a single-port data memory, using a two-cycle read-modify-write for
// sub-word stores.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              req_we,
  input  logic [2:0]        funct3,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              stall,
  output logic              err,
  output logic              err_sticky,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [31:0]       mem_wd,
  input  logic [31:0]       mem_rd
);

  lsu_state_e        state_reg;
  lsu_state_e        state_next;
  logic [31:0]       merge_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       load_data;
  logic [31:0]       merge_data;
  logic              bad_access;
  logic              accept;
  logic              rmw_start;
  logic              unused_addr_hi;

  // Byte address bits above the memory's reach simply alias.
  assign unused_addr_hi = ^addr[31:ADDR_W+2];

  lsu_lane_mux u_lane_mux (
    .mem_rd     (mem_rd),
    .wdata      (wdata),
    .byte_off   (addr[1:0]),
    .funct3     (funct3),
    .load_data  (load_data),
    .merge_data (merge_data)
  );

  assign bad_access = is_illegal(funct3, req_we) || is_misaligned(funct3, addr[1:0]);
  assign accept     = req && (state_reg == ST_IDLE) && !bad_access;
  assign err        = req && (state_reg == ST_IDLE) && bad_access;
  assign rmw_start  = accept && req_we && (funct3 != F3_W);

  // Next state and memory-side outputs; WRITE ignores the request inputs.
  always_comb begin
    state_next = state_reg;
    mem_we     = 1'b0;
    mem_addr   = addr[ADDR_W+1:2];
    mem_wd     = wdata;
    stall      = 1'b0;
    rdata      = 32'h0;
    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          if (!req_we) begin
            rdata = load_data;
          end else if (funct3 == F3_W) begin
            mem_we = 1'b1;
          end else begin
            stall      = 1'b1;
            state_next = ST_WRITE;
          end
        end
      end
      ST_WRITE: begin
        mem_we     = 1'b1;
        mem_addr   = addr_q;
        mem_wd     = merge_q;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // State register plus the RMW merge buffer and sticky error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= ST_IDLE;
      merge_q    <= 32'h0;
      addr_q     <= '0;
      err_sticky <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (rmw_start) begin
        merge_q <= merge_data;
        addr_q  <= addr[ADDR_W+1:2];
      end
      if (err) begin
        err_sticky <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural word memory attached.
module tb_load_store_unit;

  localparam int ADDR_W = 8;

  logic              clk;
  logic              rst_n;
  logic              req;
  logic              req_we;
  logic [2:0]        funct3;
  logic [31:0]       addr;
  logic [31:0]       wdata;
  logic [31:0]       rdata;
  logic              stall;
  logic              err;
  logic              err_sticky;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [31:0]       mem_wd;
  logic [31:0]       mem_rd;

  logic [31:0] mem [0:(1<<ADDR_W)-1];

  int checks   = 0;
  int failures = 0;

  load_store_unit #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .req_we     (req_we),
    .funct3     (funct3),
    .addr       (addr),
    .wdata      (wdata),
    .rdata      (rdata),
    .stall      (stall),
    .err        (err),
    .err_sticky (err_sticky),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_wd     (mem_wd),
    .mem_rd     (mem_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word memory: posedge write, combinational read.
  always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wd;
  assign mem_rd = mem[mem_addr];

  typedef struct packed {
    logic        req;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] e_rdata;
    logic        e_err;
    logic        e_we;
    logic [7:0]  e_maddr;
    logic        e_sticky;
  } vec_t;

  vec_t tbl [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic we, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd);
    req = r; req_we = we; funct3 = f3; addr = a; wdata = wd;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One-cycle word store used to set up memory contents through the DUT.
  task automatic store_word(input logic [31:0] a, input logic [31:0] d);
    drive(1'b1, 1'b1, 3'b010, a, d);
    step();
    drive(1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
  endtask

  task automatic load_check(input string name, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] exp);
    drive(1'b1, 1'b0, f3, a, 32'h0);
    @(negedge clk);
    chk(name, rdata, exp);
    $display("load f3=%0b addr=0x%03h rdata=0x%08h", f3, a, rdata);
    step();
  endtask

  initial begin
    tbl[0]  = '{1'b1, 1'b1, 3'b010, 32'h010, 32'hDEADBEEF, 32'h0,        1'b0, 1'b1, 8'h04, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 3'b010, 32'h010, 32'h0,        32'hDEADBEEF, 1'b0, 1'b0, 8'h04, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 3'b000, 32'h010, 32'h0,        32'hFFFFFFEF, 1'b0, 1'b0, 8'h04, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 3'b100, 32'h011, 32'h0,        32'h000000BE, 1'b0, 1'b0, 8'h04, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 3'b001, 32'h012, 32'h0,        32'hFFFFDEAD, 1'b0, 1'b0, 8'h04, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 3'b101, 32'h010, 32'h0,        32'h0000BEEF, 1'b0, 1'b0, 8'h04, 1'b0};
    tbl[6]  = '{1'b1, 1'b1, 3'b010, 32'h020, 32'h01234567, 32'h0,        1'b0, 1'b1, 8'h08, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 3'b000, 32'h023, 32'h0,        32'h00000001, 1'b0, 1'b0, 8'h08, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 3'b001, 32'h022, 32'h0,        32'h00000123, 1'b0, 1'b0, 8'h08, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 3'b100, 32'h020, 32'h0,        32'h00000067, 1'b0, 1'b0, 8'h08, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 3'b010, 32'h0FC, 32'h0,        32'h0,        1'b0, 1'b0, 8'h3F, 1'b0};
    tbl[11] = '{1'b1, 1'b0, 3'b010, 32'h011, 32'h0,        32'h0,        1'b1, 1'b0, 8'h04, 1'b0};
    tbl[12] = '{1'b1, 1'b1, 3'b001, 32'h013, 32'h0000FFFF, 32'h0,        1'b1, 1'b0, 8'h04, 1'b1};
    tbl[13] = '{1'b1, 1'b1, 3'b100, 32'h020, 32'h000000FF, 32'h0,        1'b1, 1'b0, 8'h08, 1'b1};
    tbl[14] = '{1'b1, 1'b0, 3'b011, 32'h020, 32'h0,        32'h0,        1'b1, 1'b0, 8'h08, 1'b1};
    tbl[15] = '{1'b1, 1'b0, 3'b010, 32'h022, 32'h0,        32'h0,        1'b1, 1'b0, 8'h08, 1'b1};

    rst_n = 1'b0;
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_mem_we", {31'h0, mem_we}, 32'h0);
    chk("reset_stall", {31'h0, stall}, 32'h0);
    chk("reset_rdata", rdata, 32'h0);
    chk("reset_err", {31'h0, err}, 32'h0);
    chk("reset_sticky", {31'h0, err_sticky}, 32'h0);
    rst_n = 1'b1;
    step();

    // Single-cycle accesses from the table.
    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].req, tbl[i].we, tbl[i].f3, tbl[i].a, tbl[i].wd);
      @(negedge clk);
      chk($sformatf("vec%0d_rdata", i), rdata, tbl[i].e_rdata);
      chk($sformatf("vec%0d_err", i), {31'h0, err}, {31'h0, tbl[i].e_err});
      chk($sformatf("vec%0d_we", i), {31'h0, mem_we}, {31'h0, tbl[i].e_we});
      chk($sformatf("vec%0d_stall", i), {31'h0, stall}, 32'h0);
      chk($sformatf("vec%0d_maddr", i), {24'h0, mem_addr}, {24'h0, tbl[i].e_maddr});
      chk($sformatf("vec%0d_sticky", i), {31'h0, err_sticky}, {31'h0, tbl[i].e_sticky});
      if (tbl[i].e_we) chk($sformatf("vec%0d_wd", i), mem_wd, tbl[i].wd);
      $display("vec%0d req=%0b we=%0b f3=%0b addr=0x%03h rdata=0x%08h err=%0b mem_we=%0b",
               i, tbl[i].req, tbl[i].we, tbl[i].f3, tbl[i].a, rdata, err, mem_we);
      step();
    end
    drive(1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
    load_check("err_store_no_write", 3'b010, 32'h020, 32'h01234567);

    // Byte RMW.
    store_word(32'h010, 32'h11223344);
    drive(1'b1, 1'b1, 3'b000, 32'h012, 32'h123456AA);
    @(negedge clk);
    chk("sb_c1_stall", {31'h0, stall}, 32'h1);
    chk("sb_c1_we", {31'h0, mem_we}, 32'h0);
    step();
    @(negedge clk);
    chk("sb_c2_we", {31'h0, mem_we}, 32'h1);
    chk("sb_c2_wd", mem_wd, 32'h11AA3344);
    chk("sb_c2_maddr", {24'h0, mem_addr}, 32'h4);
    chk("sb_c2_stall", {31'h0, stall}, 32'h0);
    $display("sb rmw addr=0x012 mem_wd=0x%08h", mem_wd);
    step();
    load_check("sb_lw", 3'b010, 32'h010, 32'h11AA3344);
    load_check("sb_lbu", 3'b100, 32'h012, 32'h000000AA);
    load_check("sb_lb", 3'b000, 32'h012, 32'hFFFFFFAA);

    // Halfword RMW.
    store_word(32'h010, 32'h11223344);
    drive(1'b1, 1'b1, 3'b001, 32'h010, 32'h00008001);
    @(negedge clk);
    chk("sh_c1_stall", {31'h0, stall}, 32'h1);
    step();
    @(negedge clk);
    chk("sh_c2_wd", mem_wd, 32'h11228001);
    $display("sh rmw addr=0x010 mem_wd=0x%08h", mem_wd);
    step();
    load_check("sh_lh", 3'b001, 32'h010, 32'hFFFF8001);
    load_check("sh_lhu", 3'b101, 32'h010, 32'h00008001);

    // Upper halfword lane.
    drive(1'b1, 1'b1, 3'b001, 32'h012, 32'h0000BEEF);
    step();
    step();
    load_check("sh_hi_lw", 3'b010, 32'h010, 32'hBEEF8001);

    // Reset during WRITE aborts the pending write and clears the sticky flag.
    store_word(32'h030, 32'hCAFEF00D);
    drive(1'b1, 1'b1, 3'b000, 32'h031, 32'h00000055);
    step();
    chk("rst_pre_we", {31'h0, mem_we}, 32'h1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_abort_we", {31'h0, mem_we}, 32'h0);
    chk("rst_sticky_clr", {31'h0, err_sticky}, 32'h0);
    $display("reset in WRITE mem_we=%0b err_sticky=%0b", mem_we, err_sticky);
    drive(1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
    step();
    rst_n = 1'b1;
    step();
    load_check("rst_word_kept", 3'b010, 32'h030, 32'hCAFEF00D);

    // Address wrap with back-to-back load; WRITE ignores a bad request.
    store_word(32'h000, 32'hA0B0C0D0);
    drive(1'b1, 1'b1, 3'b000, 32'h403, 32'h00000077);
    @(negedge clk);
    chk("wrap_c1_maddr", {24'h0, mem_addr}, 32'h0);
    step();
    drive(1'b1, 1'b0, 3'b010, 32'h011, 32'h0);
    @(negedge clk);
    chk("wrap_c2_err", {31'h0, err}, 32'h0);
    chk("wrap_c2_maddr", {24'h0, mem_addr}, 32'h0);
    chk("wrap_c2_wd", mem_wd, 32'h77B0C0D0);
    $display("wrap rmw addr=0x403 mem_wd=0x%08h", mem_wd);
    step();
    load_check("wrap_b2b_lw", 3'b010, 32'h000, 32'h77B0C0D0);
    chk("wrap_sticky", {31'h0, err_sticky}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
